// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass, per-register busy scoreboard
// and a sequential clear engine that zeroes one entry per cycle.
module regfile_scoreboard #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            clear_req,
    output logic            clear_busy
);

    // state | meaning
    // IDLE  | normal operation: reads bypass, writes and issues update state
    // CLEAR | zeroing array[cnt] each cycle; writes and issues ignored
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
    localparam bit            ZR   = (ZERO_REG != 0);

    state_t            state, state_next;
    logic [AW-1:0]     cnt;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  sb;
    logic [NREGS-1:0]  wr_mask, issue_mask;
    logic              idle, wr_ok, issue_ok, byp1, byp2;

    assign idle     = (state == IDLE);
    assign wr_ok    = idle && wr_en && !(ZR && wr_addr == '0);
    assign issue_ok = idle && issue_en && !(ZR && issue_rd == '0);
    assign wr_mask    = wr_en    ? (NREGS'(1) << wr_addr)  : '0;
    assign issue_mask = issue_ok ? (NREGS'(1) << issue_rd) : '0;
    assign byp1 = idle && wr_en && (wr_addr == rs1_addr);
    assign byp2 = idle && wr_en && (wr_addr == rs2_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear_busy = 1'b0;
        case (state)
            IDLE:  if (clear_req) state_next = CLEAR;
            CLEAR: begin
                clear_busy = 1'b1;
                if (cnt == LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            cnt <= '0;
        else if (state == CLEAR) cnt <= cnt + AW'(1);
        else                     cnt <= '0;
    end

    // A write in the clear_req cycle still lands; the engine overwrites it later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               sb <= '0;
        else if (idle && clear_req) sb <= '0;
        else if (idle)              sb <= (sb & ~wr_mask) | issue_mask;
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (byp1) rs1_data = wr_data;
        if (byp2) rs2_data = wr_data;
        if (ZR && rs1_addr == '0) rs1_data = '0;
        if (ZR && rs2_addr == '0) rs2_data = '0;
        if (!reset_n) begin
            rs1_data = '0;
            rs2_data = '0;
        end
        rs1_busy = reset_n && idle && sb[rs1_addr] && !byp1 && !(ZR && rs1_addr == '0);
        rs2_busy = reset_n && idle && sb[rs2_addr] && !byp2 && !(ZR && rs2_addr == '0);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default instance plus a
// 32-bit / 16-entry / no-zero-register instance.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [63:0] rs1_data, rs2_data, wr_data;
    logic        rs1_busy, rs2_busy, wr_en, issue_en, clear_req, clear_busy;

    logic [3:0]  rs1_addr_b, rs2_addr_b, wr_addr_b, issue_rd_b;
    logic [31:0] rs1_data_b, rs2_data_b, wr_data_b;
    logic        rs1_busy_b, rs2_busy_b, wr_en_b, issue_en_b, clear_req_b, clear_busy_b;

    regfile_scoreboard dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(16), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .rs1_addr(rs1_addr_b), .rs2_addr(rs2_addr_b),
        .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .issue_en(issue_en_b), .issue_rd(issue_rd_b),
        .clear_req(clear_req_b), .clear_busy(clear_busy_b)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        ie;
        logic [4:0]  ir;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        eb1;
        logic        eb2;
    } vec_t;

    vec_t tbl [13];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_clear(input bit use_b, output int n);
        n = 0;
        while ((use_b ? clear_busy_b : clear_busy) && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        tbl[0]  = '{1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 5'd5, 5'd0, 64'h1234, 64'h0,    1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd5, 5'd5, 64'h1234, 64'h1234, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0,    64'h0,    1'b0, 1'b0};
        tbl[3]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 5'd0, 5'd7, 64'h0,    64'h0,    1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd5, 5'd7, 64'h1234, 64'h0,    1'b0, 1'b1};
        tbl[5]  = '{1'b1, 5'd7, 64'hBEEF, 1'b0, 5'd0, 5'd7, 5'd7, 64'hBEEF, 64'hBEEF, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd7, 5'd7, 64'hBEEF, 64'hBEEF, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'd7, 64'hCAFE, 1'b1, 5'd7, 5'd3, 5'd7, 64'h0,    64'hCAFE, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd7, 5'd7, 64'hCAFE, 64'hCAFE, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd0, 5'd0, 5'd7, 64'h0,    64'hCAFE, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 5'd9, 64'h99,   1'b0, 5'd0, 5'd0, 5'd7, 64'h0,    64'hCAFE, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 5'd7, 64'h77,   1'b0, 5'd0, 5'd7, 5'd9, 64'h77,   64'h99,   1'b0, 1'b0};
        tbl[12] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 5'd7, 5'd5, 64'h77,   64'h1234, 1'b0, 1'b0};

        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hFFFF; rs1_addr = 5'd5; rs2_addr = 5'd7;
        issue_en = 1'b0; issue_rd = '0; clear_req = 1'b0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; rs1_addr_b = '0; rs2_addr_b = '0;
        issue_en_b = 1'b0; issue_rd_b = '0; clear_req_b = 1'b0;
        #1;
        check("reset rs1_data", rs1_data, 64'h0);
        check("reset rs1_busy", {63'h0, rs1_busy}, 64'h0);
        check("reset clear_busy", {63'h0, clear_busy}, 64'h0);
        repeat (2) @(negedge clk);
        wr_en = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            issue_en = tbl[i].ie; issue_rd = tbl[i].ir;
            rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
            #1;
            check($sformatf("vec%0d rs1_data", i), rs1_data, tbl[i].e1);
            check($sformatf("vec%0d rs2_data", i), rs2_data, tbl[i].e2);
            check($sformatf("vec%0d rs1_busy", i), {63'h0, rs1_busy}, {63'h0, tbl[i].eb1});
            check($sformatf("vec%0d rs2_busy", i), {63'h0, rs2_busy}, {63'h0, tbl[i].eb2});
        end

        // Fill 1..31, mark reg 4 busy, then clear.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'hA5A5; issue_en = 1'b0;
        end
        @(negedge clk);
        wr_en = 1'b0; issue_en = 1'b1; issue_rd = 5'd4;
        @(negedge clk);
        issue_en = 1'b0; rs2_addr = 5'd4; rs1_addr = 5'd31;
        #1;
        check("pre-clear busy r4", {63'h0, rs2_busy}, 64'h1);
        check("pre-clear r31", rs1_data, 64'hA5A5);
        @(negedge clk);
        clear_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h1111;
        @(negedge clk);
        clear_req = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h3333;
        issue_en = 1'b1; issue_rd = 5'd4; rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        check("clear no bypass r3", rs1_data, 64'hA5A5);
        check("clear busy r4", {63'h0, rs2_busy}, 64'h0);
        check("clear_busy high", {63'h0, clear_busy}, 64'h1);
        n = 0;
        while (clear_busy && n < 100) begin
            n++;
            @(negedge clk);
            clear_req = (n == 5);
        end
        clear_req = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
        check("clear length 32", 64'(n), 64'd32);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(i);
            #1;
            check($sformatf("post-clear r%0d data", i), rs1_data, 64'h0);
            check($sformatf("post-clear r%0d busy", i), {63'h0, rs2_busy}, 64'h0);
        end

        // Reset in the tenth clear cycle.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h2020; issue_en = 1'b1; issue_rd = 5'd8;
        @(negedge clk);
        wr_en = 1'b0; issue_en = 1'b0; clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (9) @(negedge clk);
        rs1_addr = 5'd20; rs2_addr = 5'd8;
        #1;
        check("mid-clear raw r20", rs1_data, 64'h2020);
        #2;
        reset_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'hFFFF;
        #1;
        check("reset mid-clear clear_busy", {63'h0, clear_busy}, 64'h0);
        check("reset mid-clear r20", rs1_data, 64'h0);
        check("reset mid-clear busy r8", {63'h0, rs2_busy}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1; wr_en = 1'b0;
        #1;
        check("after reset r20", rs1_data, 64'h0);
        check("after reset clear_busy", {63'h0, clear_busy}, 64'h0);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        count_clear(1'b0, n);
        check("clear after reset length", 64'(n), 64'd32);

        // Second configuration: reg 0 is ordinary.
        @(negedge clk);
        wr_en_b = 1'b1; wr_addr_b = 4'd0; wr_data_b = 32'h55;
        @(negedge clk);
        wr_en_b = 1'b0; rs1_addr_b = 4'd0; rs2_addr_b = 4'd0;
        issue_en_b = 1'b1; issue_rd_b = 4'd0;
        #1;
        check("b r0 data", {32'h0, rs1_data_b}, 64'h55);
        @(negedge clk);
        issue_en_b = 1'b0;
        #1;
        check("b r0 busy", {63'h0, rs2_busy_b}, 64'h1);
        clear_req_b = 1'b1;
        @(negedge clk);
        clear_req_b = 1'b0;
        count_clear(1'b1, n);
        check("b clear length 16", 64'(n), 64'd16);
        #1;
        check("b post-clear r0", {32'h0, rs1_data_b}, 64'h0);
        check("b post-clear busy", {63'h0, rs2_busy_b}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
